// File: rtl/riscv_v_scoreboard_pkg.sv
// Shared sizes, types and helpers for the vector register scoreboard.
package riscv_v_scoreboard_pkg;

  localparam int RISCV_V_NUM_VREGS  = 32;
  localparam int RISCV_V_ADDR_W     = $clog2(RISCV_V_NUM_VREGS);
  localparam int RISCV_V_SB_LAT_W   = 3;
  localparam int RISCV_V_SB_TIMEOUT = 4;
  localparam int RISCV_V_SB_TO_W    = $clog2(RISCV_V_SB_TIMEOUT + 1);

  typedef logic [RISCV_V_ADDR_W-1:0]    riscv_v_rf_addr_t;
  typedef logic [RISCV_V_SB_LAT_W-1:0]  riscv_v_sb_lat_t;
  typedef logic [RISCV_V_NUM_VREGS-1:0] riscv_v_busy_vec_t;
  typedef logic [RISCV_V_ADDR_W:0]      riscv_v_sb_cnt_t;
  typedef logic [RISCV_V_SB_TO_W-1:0]   riscv_v_sb_to_t;

  function automatic riscv_v_sb_cnt_t riscv_v_popcount(input riscv_v_busy_vec_t v);
    riscv_v_sb_cnt_t c;
    c = '0;
    for (int i = 0; i < RISCV_V_NUM_VREGS; i++) begin
      c = c + riscv_v_sb_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/riscv_v_scoreboard_if.sv
// ID-stage issue, write-back and kill signals plus stall/status returned by the scoreboard.
interface riscv_v_scoreboard_if;
  import riscv_v_scoreboard_pkg::*;

  logic              issue_valid_id;
  riscv_v_rf_addr_t  vs1_id;
  logic              vs1_used_id;
  riscv_v_rf_addr_t  vs2_id;
  logic              vs2_used_id;
  riscv_v_rf_addr_t  vd_id;
  logic              vd_wr_id;
  riscv_v_sb_lat_t   lat_id;
  logic              wb_valid;
  riscv_v_rf_addr_t  wb_addr;
  logic              flush;
  logic              clear_pipe;
  logic              stall;
  logic              issue_fire;
  riscv_v_busy_vec_t busy_vec;
  riscv_v_sb_cnt_t   pending_cnt;
  logic              err_timeout;

  modport master (
    output issue_valid_id, vs1_id, vs1_used_id, vs2_id, vs2_used_id,
           vd_id, vd_wr_id, lat_id, wb_valid, wb_addr, flush, clear_pipe,
    input  stall, issue_fire, busy_vec, pending_cnt, err_timeout
  );

  modport slave (
    input  issue_valid_id, vs1_id, vs1_used_id, vs2_id, vs2_used_id,
           vd_id, vd_wr_id, lat_id, wb_valid, wb_addr, flush, clear_pipe,
    output stall, issue_fire, busy_vec, pending_cnt, err_timeout
  );

endinterface

// File: rtl/riscv_v_sb_entry.sv
// One vector register's pending-write tracker: busy flag, latency countdown, lost-WB timeout.
// Busy is visible the cycle after set; timeout_o pulses in the cycle the entry self-clears.
module riscv_v_sb_entry
  import riscv_v_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  riscv_v_sb_lat_t lat_i,
  input  logic            retire_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            timeout_o
);

  logic            busy_q;
  riscv_v_sb_lat_t cnt_q;
  riscv_v_sb_to_t  to_q;
  riscv_v_sb_lat_t lat_eff;

  assign lat_eff   = (lat_i == '0) ? riscv_v_sb_lat_t'(1) : lat_i;
  assign busy_o    = busy_q;
  // A set can only coincide with a busy entry when that entry is retiring, so it never masks a real loss.
  assign timeout_o = busy_q & (cnt_q == '0) &
                     (to_q == riscv_v_sb_to_t'(RISCV_V_SB_TIMEOUT - 1)) &
                     ~retire_i & ~kill_i & ~set_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      to_q   <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      to_q   <= '0;
    end else if (set_i) begin
      busy_q <= 1'b1;
      cnt_q  <= lat_eff;
      to_q   <= '0;
    end else if (retire_i || timeout_o) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      to_q   <= '0;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - riscv_v_sb_lat_t'(1);
      end else begin
        to_q  <= to_q + riscv_v_sb_to_t'(1);
      end
    end
  end

endmodule

// File: rtl/riscv_v_scoreboard.sv
// Vector RF scoreboard: RAW/WAW hazard stall for ID, flush/clear_pipe cancel, sticky lost-WB error.
// stall/issue_fire are combinational (zero latency); busy state updates at the next edge.
module riscv_v_scoreboard
  import riscv_v_scoreboard_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  riscv_v_scoreboard_if.slave  sb
);

  riscv_v_busy_vec_t busy;
  riscv_v_busy_vec_t retiring;
  riscv_v_busy_vec_t set_vec;
  riscv_v_busy_vec_t kill_vec;
  riscv_v_busy_vec_t to_vec;
  logic              raw, waw, stall, fire;
  riscv_v_rf_addr_t  last_vd_q, last_vd_d;
  logic              last_vd_valid_q, last_vd_valid_d;
  logic              err_q, err_d;

  always_comb begin
    retiring = '0;
    if (sb.wb_valid) retiring[sb.wb_addr] = 1'b1;
  end

  // A register being written back this cycle is already forwarded by the RF, so it does not hazard.
  assign raw   = (sb.vs1_used_id & busy[sb.vs1_id] & ~retiring[sb.vs1_id]) |
                 (sb.vs2_used_id & busy[sb.vs2_id] & ~retiring[sb.vs2_id]);
  assign waw   = sb.vd_wr_id & busy[sb.vd_id] & ~retiring[sb.vd_id];
  assign stall = sb.issue_valid_id & (raw | waw);
  assign fire  = sb.issue_valid_id & ~stall & ~sb.flush & ~sb.clear_pipe;

  always_comb begin
    set_vec  = '0;
    kill_vec = '0;
    if (fire && sb.vd_wr_id) set_vec[sb.vd_id] = 1'b1;
    if (sb.clear_pipe) begin
      kill_vec = '1;
    end else if (sb.flush && last_vd_valid_q) begin
      kill_vec[last_vd_q] = 1'b1;
    end
  end

  always_comb begin
    last_vd_d       = last_vd_q;
    last_vd_valid_d = 1'b0;
    if (fire && sb.vd_wr_id) begin
      last_vd_d       = sb.vd_id;
      last_vd_valid_d = 1'b1;
    end
    err_d = err_q | (|to_vec);
  end

  for (genvar i = 0; i < RISCV_V_NUM_VREGS; i++) begin : g_entry
    riscv_v_sb_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .set_i     (set_vec[i]),
      .lat_i     (sb.lat_id),
      .retire_i  (retiring[i]),
      .kill_i    (kill_vec[i]),
      .busy_o    (busy[i]),
      .timeout_o (to_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vd_q       <= '0;
      last_vd_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      last_vd_q       <= last_vd_d;
      last_vd_valid_q <= last_vd_valid_d;
      err_q           <= err_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.issue_fire  = fire;
  assign sb.busy_vec    = busy;
  assign sb.pending_cnt = riscv_v_popcount(busy);
  assign sb.err_timeout = err_q;

endmodule
